// File: rtl/axis_fork_scheduler_if.sv
// AXI-Stream style handshake bundle shared by the upstream and gated
// downstream sides of the fork scheduler.
`timescale 1ns/1ps
interface axis_fork_scheduler_if #(
  parameter int DATA_WIDTH = 64
) ();
  logic [DATA_WIDTH-1:0] tdata;
  logic                  tlast;
  logic                  tvalid;
  logic                  tready;

  modport master (output tdata, output tlast, output tvalid, input tready);
  modport slave  (input tdata, input tlast, input tvalid, output tready);
endinterface

// File: rtl/axis_fork_scheduler.sv
// Job scheduler that gates an AXI-Stream toward a fork arbiter for a fixed
// number of frames, tracks delivery, and guards the job with an idle timeout.
`timescale 1ns/1ps
module axis_fork_scheduler #(
  parameter int DATA_WIDTH = 64,
  parameter int CNT_WIDTH  = 16,
  parameter int TO_WIDTH   = 20
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic                  abort,
  input  logic [CNT_WIDTH-1:0]  cfg_frame_count,
  input  logic [TO_WIDTH-1:0]   cfg_timeout,
  axis_fork_scheduler_if.slave  s_axis,
  axis_fork_scheduler_if.master m_axis,
  output logic                  fork_enable,
  input  logic                  fork_done,
  output logic                  busy,
  output logic                  done,
  output logic                  error,
  output logic [CNT_WIDTH-1:0]  frames_in,
  output logic [CNT_WIDTH-1:0]  frames_out
);

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_RUN   = 3'd1,
    ST_DRAIN = 3'd2,
    ST_DONE  = 3'd3,
    ST_ERR   = 3'd4
  } state_t;

  localparam logic [CNT_WIDTH-1:0] CNT_ZERO = {CNT_WIDTH{1'b0}};
  localparam logic [CNT_WIDTH-1:0] CNT_ONE  = {{(CNT_WIDTH-1){1'b0}}, 1'b1};
  localparam logic [TO_WIDTH-1:0]  TO_ZERO  = {TO_WIDTH{1'b0}};
  localparam logic [TO_WIDTH-1:0]  TO_ONE   = {{(TO_WIDTH-1){1'b0}}, 1'b1};
  localparam logic [TO_WIDTH-1:0]  TO_MAX   = {TO_WIDTH{1'b1}};

  state_t               state_r, state_nxt_s;
  logic [CNT_WIDTH-1:0] target_r, frames_in_r, frames_out_r;
  logic [CNT_WIDTH-1:0] frames_in_nxt_s, frames_out_nxt_s;
  logic [TO_WIDTH-1:0]  timeout_r, idle_r, idle_nxt_s;
  logic                 fork_enable_r, busy_r, done_r, error_r, error_nxt_s;
  logic                 open_s, beat_s, last_beat_s, activity_s, in_job_s;
  logic                 accept_start_s, timeout_hit_s;

  // The gate is purely combinational; only RUN lets beats through.
  assign open_s        = (state_r == ST_RUN);
  assign m_axis.tdata  = s_axis.tdata[DATA_WIDTH-1:0];
  assign m_axis.tlast  = s_axis.tlast;
  assign m_axis.tvalid = s_axis.tvalid & open_s;
  assign s_axis.tready = m_axis.tready & open_s;

  assign beat_s         = s_axis.tvalid & m_axis.tready & open_s;
  assign last_beat_s    = beat_s & s_axis.tlast;
  assign activity_s     = beat_s | fork_done;
  assign in_job_s       = (state_r == ST_RUN) || (state_r == ST_DRAIN);
  assign accept_start_s = start & ~abort & ((state_r == ST_IDLE) || (state_r == ST_ERR));
  assign timeout_hit_s  = in_job_s & (timeout_r != TO_ZERO) & ~activity_s & (idle_r >= timeout_r);

  assign fork_enable = fork_enable_r;
  assign busy        = busy_r;
  assign done        = done_r;
  assign error       = error_r;
  assign frames_in   = frames_in_r;
  assign frames_out  = frames_out_r;

  // Next-state, counter and error-flag decisions.
  always_comb begin
    state_nxt_s      = state_r;
    frames_in_nxt_s  = frames_in_r;
    frames_out_nxt_s = frames_out_r;
    idle_nxt_s       = idle_r;
    error_nxt_s      = error_r;

    // Counters freeze in the abort cycle so the status reflects the job as cut off.
    if (in_job_s && !abort) begin
      if (last_beat_s) begin
        frames_in_nxt_s = frames_in_r + CNT_ONE;
      end else begin
        frames_in_nxt_s = frames_in_r;
      end
      if (fork_done && (frames_out_r < target_r)) begin
        frames_out_nxt_s = frames_out_r + CNT_ONE;
      end else begin
        frames_out_nxt_s = frames_out_r;
      end
      if (activity_s) begin
        idle_nxt_s = TO_ZERO;
      end else if (idle_r != TO_MAX) begin
        idle_nxt_s = idle_r + TO_ONE;
      end else begin
        idle_nxt_s = idle_r;
      end
    end else begin
      idle_nxt_s = idle_r;
    end

    case (state_r)
      ST_IDLE, ST_ERR: begin
        if (abort) begin
          state_nxt_s = ST_IDLE;
        end else if (start) begin
          frames_in_nxt_s  = CNT_ZERO;
          frames_out_nxt_s = CNT_ZERO;
          idle_nxt_s       = TO_ZERO;
          error_nxt_s      = 1'b0;
          state_nxt_s      = (cfg_frame_count != CNT_ZERO) ? ST_RUN : ST_DONE;
        end else begin
          state_nxt_s = state_r;
        end
      end
      ST_RUN: begin
        if (abort) begin
          state_nxt_s = ST_IDLE;
        end else if (last_beat_s && (frames_in_nxt_s == target_r)) begin
          state_nxt_s = ST_DRAIN;
        end else if (timeout_hit_s) begin
          state_nxt_s = ST_ERR;
          error_nxt_s = 1'b1;
        end else begin
          state_nxt_s = ST_RUN;
        end
      end
      ST_DRAIN: begin
        if (abort) begin
          state_nxt_s = ST_IDLE;
        end else if (frames_out_nxt_s == target_r) begin
          state_nxt_s = ST_DONE;
        end else if (timeout_hit_s) begin
          state_nxt_s = ST_ERR;
          error_nxt_s = 1'b1;
        end else begin
          state_nxt_s = ST_DRAIN;
        end
      end
      ST_DONE: begin
        state_nxt_s = ST_IDLE;
      end
      default: begin
        state_nxt_s = ST_IDLE;
      end
    endcase
  end

  // State, counters, latched configuration and registered control outputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r       <= ST_IDLE;
      target_r      <= CNT_ZERO;
      timeout_r     <= TO_ZERO;
      frames_in_r   <= CNT_ZERO;
      frames_out_r  <= CNT_ZERO;
      idle_r        <= TO_ZERO;
      error_r       <= 1'b0;
      fork_enable_r <= 1'b0;
      busy_r        <= 1'b0;
      done_r        <= 1'b0;
    end else begin
      state_r      <= state_nxt_s;
      frames_in_r  <= frames_in_nxt_s;
      frames_out_r <= frames_out_nxt_s;
      idle_r       <= idle_nxt_s;
      error_r      <= error_nxt_s;
      if (accept_start_s) begin
        target_r  <= cfg_frame_count;
        timeout_r <= cfg_timeout;
      end
      // Outputs decode the upcoming state so they line up with it exactly.
      fork_enable_r <= (state_nxt_s == ST_RUN) || (state_nxt_s == ST_DRAIN);
      busy_r        <= (state_nxt_s == ST_RUN) || (state_nxt_s == ST_DRAIN);
      done_r        <= (state_nxt_s == ST_DONE);
    end
  end

endmodule

// File: tb/tb_axis_fork_scheduler.sv
// Directed bench for axis_fork_scheduler: a cycle table for the basic job
// flow plus hand sequences for the long jobs, timeout, abort and reset.
`timescale 1ns/1ps
module tb_axis_fork_scheduler;

  logic        clk = 1'b0;
  logic        rst;
  logic        start, abort, fork_done;
  logic [15:0] cfg_frame_count;
  logic [19:0] cfg_timeout;
  logic        fork_enable, busy, done, error;
  logic [15:0] frames_in, frames_out;

  axis_fork_scheduler_if #(.DATA_WIDTH(64)) s_axis ();
  axis_fork_scheduler_if #(.DATA_WIDTH(64)) m_axis ();

  axis_fork_scheduler #(.DATA_WIDTH(64), .CNT_WIDTH(16), .TO_WIDTH(20)) dut (
    .clk(clk), .rst(rst), .start(start), .abort(abort),
    .cfg_frame_count(cfg_frame_count), .cfg_timeout(cfg_timeout),
    .s_axis(s_axis), .m_axis(m_axis),
    .fork_enable(fork_enable), .fork_done(fork_done),
    .busy(busy), .done(done), .error(error),
    .frames_in(frames_in), .frames_out(frames_out)
  );

  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;
  int done_cnt = 0;

  always @(negedge clk) begin
    if (done === 1'b1) done_cnt <= done_cnt + 1;
  end

  typedef struct {
    logic        start, abort;
    logic [15:0] cnt;
    logic [19:0] to;
    logic        tv, tl, mr, fd;
    logic [63:0] data;
    logic        e_tr, e_mv, e_busy, e_fe, e_done, e_err;
    logic [15:0] e_fin, e_fout;
  } vec_t;

  vec_t vt [13];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  task automatic set_in(input logic st, input logic ab, input logic [15:0] cnt, input logic [19:0] to,
                        input logic tv, input logic tl, input logic mr, input logic fd);
    start = st; abort = ab; cfg_frame_count = cnt; cfg_timeout = to;
    s_axis.tvalid = tv; s_axis.tlast = tl; m_axis.tready = mr; fork_done = fd;
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  initial begin
    int d0;
    int fe_low;

    //             st    ab    cnt     to     tv    tl    mr    fd    data          tr    mv    busy  fe    done  err   fin     fout
    vt[0]  = '{1'b0, 1'b0, 16'd0, 20'd0, 1'b1, 1'b0, 1'b1, 1'b0, 64'h0000_00A0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 16'd0, 16'd0};
    vt[1]  = '{1'b1, 1'b0, 16'd2, 20'd0, 1'b0, 1'b0, 1'b1, 1'b0, 64'h0000_00A1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 16'd0, 16'd0};
    vt[2]  = '{1'b0, 1'b0, 16'd0, 20'd0, 1'b1, 1'b0, 1'b1, 1'b0, 64'hDEAD_BEEF_0000_0002, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 16'd0, 16'd0};
    vt[3]  = '{1'b0, 1'b0, 16'd0, 20'd0, 1'b1, 1'b1, 1'b1, 1'b0, 64'h1234_5678_9ABC_DEF0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 16'd1, 16'd0};
    vt[4]  = '{1'b0, 1'b0, 16'd0, 20'd0, 1'b1, 1'b0, 1'b0, 1'b0, 64'h0000_00A4, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 16'd1, 16'd0};
    vt[5]  = '{1'b0, 1'b0, 16'd0, 20'd0, 1'b1, 1'b1, 1'b1, 1'b1, 64'hFFFF_0000_FFFF_0005, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 16'd2, 16'd1};
    vt[6]  = '{1'b1, 1'b0, 16'd7, 20'd0, 1'b1, 1'b0, 1'b1, 1'b0, 64'h0000_00A6, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 16'd2, 16'd1};
    vt[7]  = '{1'b0, 1'b0, 16'd0, 20'd0, 1'b1, 1'b0, 1'b1, 1'b1, 64'h0000_00A7, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 16'd2, 16'd2};
    vt[8]  = '{1'b0, 1'b0, 16'd0, 20'd0, 1'b1, 1'b0, 1'b1, 1'b1, 64'h0000_00A8, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 16'd2, 16'd2};
    vt[9]  = '{1'b1, 1'b1, 16'd5, 20'd0, 1'b0, 1'b0, 1'b1, 1'b0, 64'h0000_00A9, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 16'd2, 16'd2};
    vt[10] = '{1'b1, 1'b0, 16'd0, 20'd0, 1'b0, 1'b0, 1'b1, 1'b0, 64'h0000_00AA, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 16'd0, 16'd0};
    vt[11] = '{1'b0, 1'b0, 16'd0, 20'd0, 1'b0, 1'b0, 1'b1, 1'b0, 64'h0000_00AB, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 16'd0, 16'd0};
    vt[12] = '{1'b0, 1'b0, 16'd0, 20'd0, 1'b0, 1'b0, 1'b1, 1'b1, 64'h0000_00AC, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 16'd0, 16'd0};

    // Reset state, with upstream offering and downstream ready.
    rst = 1'b1;
    s_axis.tdata = 64'h0;
    set_in(1'b0, 1'b0, 16'd0, 20'd0, 1'b1, 1'b0, 1'b1, 1'b0);
    repeat (3) @(posedge clk);
    #2;
    chk("rst_tready", 64'(s_axis.tready), 64'd0);
    chk("rst_tvalid", 64'(m_axis.tvalid), 64'd0);
    chk("rst_busy",   64'(busy),   64'd0);
    chk("rst_fe",     64'(fork_enable), 64'd0);
    chk("rst_fin",    64'(frames_in),   64'd0);
    @(negedge clk);
    rst = 1'b0;
    cyc();

    // Table: count=2 job with a third frame offered, count=0 job, start+abort.
    for (int i = 0; i < 13; i++) begin
      set_in(vt[i].start, vt[i].abort, vt[i].cnt, vt[i].to, vt[i].tv, vt[i].tl, vt[i].mr, vt[i].fd);
      s_axis.tdata = vt[i].data;
      #1;
      chk($sformatf("v%0d_tready", i), 64'(s_axis.tready), 64'(vt[i].e_tr));
      chk($sformatf("v%0d_tvalid", i), 64'(m_axis.tvalid), 64'(vt[i].e_mv));
      chk($sformatf("v%0d_tdata", i),  m_axis.tdata,       vt[i].data);
      chk($sformatf("v%0d_tlast", i),  64'(m_axis.tlast),  64'(vt[i].tl));
      cyc();
      chk($sformatf("v%0d_busy", i),   64'(busy),        64'(vt[i].e_busy));
      chk($sformatf("v%0d_fe", i),     64'(fork_enable), 64'(vt[i].e_fe));
      chk($sformatf("v%0d_done", i),   64'(done),        64'(vt[i].e_done));
      chk($sformatf("v%0d_err", i),    64'(error),       64'(vt[i].e_err));
      chk($sformatf("v%0d_fin", i),    64'(frames_in),   64'(vt[i].e_fin));
      chk($sformatf("v%0d_fout", i),   64'(frames_out),  64'(vt[i].e_fout));
    end

    // Three 4-beat frames, fork_done after each.
    set_in(1'b0, 1'b0, 16'd0, 20'd0, 1'b0, 1'b0, 1'b1, 1'b0);
    cyc();
    d0 = done_cnt;
    fe_low = 0;
    set_in(1'b1, 1'b0, 16'd3, 20'd0, 1'b0, 1'b0, 1'b1, 1'b0);
    cyc();
    if (fork_enable !== 1'b1) fe_low++;
    for (int f = 0; f < 3; f++) begin
      for (int b = 0; b < 4; b++) begin
        set_in(1'b0, 1'b0, 16'd0, 20'd0, 1'b1, (b == 3), 1'b1, 1'b0);
        cyc();
        if (fork_enable !== 1'b1) fe_low++;
      end
      set_in(1'b0, 1'b0, 16'd0, 20'd0, 1'b0, 1'b0, 1'b1, 1'b1);
      cyc();
      if (f < 2 && fork_enable !== 1'b1) fe_low++;
    end
    fork_done = 1'b0;
    chk("a_done_now", 64'(done), 64'd1);
    chk("a_fe_off",   64'(fork_enable), 64'd0);
    repeat (3) cyc();
    chk("a_fe_low_cycles", 64'(fe_low), 64'd0);
    chk("a_done_pulses",   64'(done_cnt - d0), 64'd1);
    chk("a_fin",  64'(frames_in),  64'd3);
    chk("a_fout", 64'(frames_out), 64'd3);

    // Timeout: count=1, timeout=10, fork_done withheld.
    d0 = done_cnt;
    set_in(1'b1, 1'b0, 16'd1, 20'd10, 1'b0, 1'b0, 1'b1, 1'b0);
    cyc();
    set_in(1'b0, 1'b0, 16'd0, 20'd0, 1'b1, 1'b1, 1'b1, 1'b0);
    cyc();
    set_in(1'b0, 1'b0, 16'd0, 20'd0, 1'b0, 1'b0, 1'b1, 1'b0);
    repeat (10) cyc();
    chk("b_err_early", 64'(error), 64'd0);
    chk("b_fe_early",  64'(fork_enable), 64'd1);
    cyc();
    chk("b_err",  64'(error), 64'd1);
    chk("b_fe",   64'(fork_enable), 64'd0);
    chk("b_busy", 64'(busy), 64'd0);
    chk("b_fin",  64'(frames_in), 64'd1);
    set_in(1'b0, 1'b0, 16'd0, 20'd0, 1'b1, 1'b0, 1'b1, 1'b0);
    #1;
    chk("b_err_tready", 64'(s_axis.tready), 64'd0);
    set_in(1'b0, 1'b1, 16'd0, 20'd0, 1'b0, 1'b0, 1'b1, 1'b0);
    cyc();
    abort = 1'b0;
    chk("b_err_sticky", 64'(error), 64'd1);
    chk("b_no_done",    64'(done_cnt - d0), 64'd0);

    // Abort mid-RUN after one of four frames.
    d0 = done_cnt;
    set_in(1'b1, 1'b0, 16'd4, 20'd0, 1'b0, 1'b0, 1'b1, 1'b0);
    cyc();
    chk("c_err_cleared", 64'(error), 64'd0);
    chk("c_fe_on",       64'(fork_enable), 64'd1);
    set_in(1'b0, 1'b0, 16'd0, 20'd0, 1'b1, 1'b0, 1'b1, 1'b0);
    cyc();
    s_axis.tlast = 1'b1;
    cyc();
    set_in(1'b0, 1'b1, 16'd0, 20'd0, 1'b0, 1'b0, 1'b1, 1'b0);
    cyc();
    abort = 1'b0;
    chk("c_busy", 64'(busy), 64'd0);
    chk("c_fe",   64'(fork_enable), 64'd0);
    chk("c_fin",  64'(frames_in), 64'd1);
    set_in(1'b0, 1'b0, 16'd0, 20'd0, 1'b1, 1'b0, 1'b1, 1'b0);
    #1;
    chk("c_tready", 64'(s_axis.tready), 64'd0);
    cyc();
    chk("c_no_done", 64'(done_cnt - d0), 64'd0);
    chk("c_fin_hold", 64'(frames_in), 64'd1);

    // Reset asserted in DRAIN, then a normal job.
    set_in(1'b1, 1'b0, 16'd2, 20'd0, 1'b0, 1'b0, 1'b1, 1'b0);
    cyc();
    set_in(1'b0, 1'b0, 16'd0, 20'd0, 1'b1, 1'b1, 1'b1, 1'b0);
    cyc();
    cyc();
    s_axis.tlast = 1'b0;
    chk("d_drain_busy", 64'(busy), 64'd1);
    chk("d_drain_fin",  64'(frames_in), 64'd2);
    #2;
    rst = 1'b1;
    #1;
    chk("d_rst_busy",   64'(busy), 64'd0);
    chk("d_rst_fe",     64'(fork_enable), 64'd0);
    chk("d_rst_done",   64'(done), 64'd0);
    chk("d_rst_fin",    64'(frames_in), 64'd0);
    chk("d_rst_fout",   64'(frames_out), 64'd0);
    chk("d_rst_tready", 64'(s_axis.tready), 64'd0);
    chk("d_rst_tvalid", 64'(m_axis.tvalid), 64'd0);
    @(posedge clk);
    #3;
    rst = 1'b0;
    d0 = done_cnt;
    set_in(1'b1, 1'b0, 16'd1, 20'd5, 1'b0, 1'b0, 1'b1, 1'b0);
    cyc();
    chk("d_run_fe", 64'(fork_enable), 64'd1);
    set_in(1'b0, 1'b0, 16'd0, 20'd0, 1'b1, 1'b1, 1'b1, 1'b0);
    cyc();
    set_in(1'b0, 1'b0, 16'd0, 20'd0, 1'b0, 1'b0, 1'b1, 1'b1);
    cyc();
    fork_done = 1'b0;
    chk("d_done", 64'(done), 64'd1);
    chk("d_fin",  64'(frames_in), 64'd1);
    chk("d_fout", 64'(frames_out), 64'd1);
    cyc();
    chk("d_done_once", 64'(done_cnt - d0), 64'd1);
    chk("d_err", 64'(error), 64'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
